issue_scheduler: RTL and testbench

//  Picks which ready reservation-station entries issue each cycle and drives the functional-unit busy table.

---
 rtl/issue_scheduler_pkg.sv | 23 ++
 rtl/age_select.sv | 35 +++
 rtl/issue_scheduler.sv | 124 ++++++++++++
 tb/tb_issue_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared sizes, FU indices and LSU state encoding for the issue scheduler.
package issue_scheduler_pkg;

  localparam int unsigned RS_ENTRIES = 16;
  localparam int unsigned IDX_WIDTH  = 4;
  localparam int unsigned ROB_WIDTH  = 6;
  localparam int unsigned NUM_FU     = 3;

  localparam int unsigned FU_ALU0 = 0;
  localparam int unsigned FU_ALU1 = 1;
  localparam int unsigned FU_LSU  = 2;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_t;

  function automatic logic [RS_ENTRIES-1:0] idx_onehot(input logic [IDX_WIDTH-1:0] idx);
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/age_select.sv
// Oldest-candidate finder: smallest (tag - head) mod 2**TAG_W wins, lower index breaks ties.
module age_select
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned N     = RS_ENTRIES,
  parameter int unsigned TAG_W = ROB_WIDTH,
  parameter int unsigned IDX_W = IDX_WIDTH
) (
  input  logic [N-1:0]       cand,
  input  logic [N*TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]   head,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [TAG_W-1:0] age;
  logic [TAG_W-1:0] best_age;

  // Strict less-than keeps the earlier (lower) index on equal age.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    best_age = '0;
    age      = '0;
    for (int i = 0; i < N; i++) begin
      age = tags[i*TAG_W +: TAG_W] - head;
      if (cand[i] && (!found || (age < best_age))) begin
        found    = 1'b1;
        best_age = age;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Oldest-first issue to ALU0/ALU1/LSU with registered grants, in-flight mask and LSU busy FSM.
module issue_scheduler
  import issue_scheduler_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [RS_ENTRIES-1:0]          rs_ready,
  input  logic [RS_ENTRIES-1:0]          rs_is_mem,
  input  logic [RS_ENTRIES*ROB_WIDTH-1:0] rs_rob_num,
  input  logic [ROB_WIDTH-1:0]           rob_head,
  input  logic [NUM_FU-1:0]              fu_en,
  input  logic                           lsu_done,
  output logic [NUM_FU-1:0]              grant_valid,
  output logic [NUM_FU*IDX_WIDTH-1:0]    grant_idx,
  output logic [NUM_FU-1:0]              fu_busy
);

  lsu_state_t state, state_next;

  logic [RS_ENTRIES-1:0]       inflight_c;
  logic [RS_ENTRIES-1:0]       elig_c;
  logic [RS_ENTRIES-1:0]       alu_cand_c;
  logic [RS_ENTRIES-1:0]       alu1_cand_c;
  logic [RS_ENTRIES-1:0]       mem_cand_c;
  logic                        found0, found1, foundl;
  logic [IDX_WIDTH-1:0]        idx0, idx1, idxl;
  logic [NUM_FU-1:0]           pick_c;
  logic [NUM_FU*IDX_WIDTH-1:0] grant_idx_c;
  logic                        lsu_accept_c;

  // Entries granted last cycle are still held ready by rs for one more cycle.
  always_comb begin
    inflight_c = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (grant_valid[k]) begin
        inflight_c = inflight_c | idx_onehot(grant_idx[k*IDX_WIDTH +: IDX_WIDTH]);
      end
    end
  end

  assign elig_c      = rs_ready & ~inflight_c;
  assign alu_cand_c  = elig_c & ~rs_is_mem;
  assign mem_cand_c  = elig_c & rs_is_mem;
  assign alu1_cand_c = alu_cand_c &
                       ~((fu_en[FU_ALU0] && found0) ? idx_onehot(idx0) : RS_ENTRIES'(0));

  age_select u_sel_alu0 (
    .cand  (alu_cand_c),
    .tags  (rs_rob_num),
    .head  (rob_head),
    .found (found0),
    .idx   (idx0)
  );

  age_select u_sel_alu1 (
    .cand  (alu1_cand_c),
    .tags  (rs_rob_num),
    .head  (rob_head),
    .found (found1),
    .idx   (idx1)
  );

  age_select u_sel_lsu (
    .cand  (mem_cand_c),
    .tags  (rs_rob_num),
    .head  (rob_head),
    .found (foundl),
    .idx   (idxl)
  );

  always_comb begin
    pick_c          = '0;
    pick_c[FU_ALU0] = fu_en[FU_ALU0] & found0;
    pick_c[FU_ALU1] = fu_en[FU_ALU1] & found1;
    pick_c[FU_LSU]  = fu_en[FU_LSU] & foundl & lsu_accept_c;
    grant_idx_c     = {(pick_c[FU_LSU]  ? idxl : IDX_WIDTH'(0)),
                       (pick_c[FU_ALU1] ? idx1 : IDX_WIDTH'(0)),
                       (pick_c[FU_ALU0] ? idx0 : IDX_WIDTH'(0))};
  end

  // LSU FSM state register
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= LSU_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // LSU FSM next state: a completing op may hand straight over to the next one
  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE: if (pick_c[FU_LSU]) state_next = LSU_BUSY;
      LSU_BUSY: if (lsu_done && !pick_c[FU_LSU]) state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  // LSU FSM outputs
  always_comb begin
    lsu_accept_c = 1'b0;
    case (state)
      LSU_IDLE: lsu_accept_c = 1'b1;
      LSU_BUSY: lsu_accept_c = lsu_done;
      default:  lsu_accept_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      grant_valid <= '0;
      grant_idx   <= '0;
      fu_busy     <= '0;
    end else begin
      grant_valid <= pick_c;
      grant_idx   <= grant_idx_c;
      fu_busy     <= {((state_next == LSU_BUSY) | ~fu_en[FU_LSU]),
                      ~fu_en[FU_ALU1], ~fu_en[FU_ALU0]};
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed and random checks of issue_scheduler against a priority-key reference model.
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst, flush, lsu_done;
  logic [15:0] rs_ready, rs_is_mem;
  logic [95:0] rs_rob_num;
  logic [5:0]  rob_head;
  logic [2:0]  fu_en;
  logic [2:0]  grant_valid, fu_busy;
  logic [11:0] grant_idx;

  int total = 0;
  int bad   = 0;

  // Reference state: what the outputs should be after the next edge
  logic [2:0]  m_gv, m_busy;
  logic [11:0] m_gi;
  bit          m_lsu_busy;

  issue_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .rs_ready   (rs_ready),
    .rs_is_mem  (rs_is_mem),
    .rs_rob_num (rs_rob_num),
    .rob_head   (rob_head),
    .fu_en      (fu_en),
    .lsu_done   (lsu_done),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .fu_busy    (fu_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_tag(input int i, input logic [5:0] t);
    rs_rob_num[i*6 +: 6] = t;
  endtask

  // Oldest candidate: minimise (age * 16 + index), -1 when empty
  function automatic int oldest(input logic [15:0] cand);
    int best, best_key, key, age;
    best = -1;
    best_key = 0;
    for (int i = 0; i < 16; i++) begin
      if (cand[i]) begin
        age = (int'(rs_rob_num[i*6 +: 6]) - int'(rob_head) + 64) % 64;
        key = age * 16 + i;
        if (best < 0 || key < best_key) begin
          best = i;
          best_key = key;
        end
      end
    end
    return best;
  endfunction

  task automatic model_edge();
    logic [15:0] infl, alu, mem, alu1;
    int w0, w1, wl;
    bit g0, g1, gl, acc;
    if (rst || flush) begin
      m_gv = '0; m_gi = '0; m_busy = '0; m_lsu_busy = 0;
    end else begin
      infl = '0;
      for (int k = 0; k < 3; k++)
        if (m_gv[k]) infl[m_gi[k*4 +: 4]] = 1'b1;
      alu = rs_ready & ~infl & ~rs_is_mem;
      mem = rs_ready & ~infl & rs_is_mem;
      w0 = oldest(alu);
      g0 = fu_en[0] && (w0 >= 0);
      alu1 = alu;
      if (g0) alu1[w0] = 1'b0;
      w1 = oldest(alu1);
      g1 = fu_en[1] && (w1 >= 0);
      acc = !m_lsu_busy || lsu_done;
      wl = oldest(mem);
      gl = fu_en[2] && acc && (wl >= 0);
      if (gl) m_lsu_busy = 1;
      else if (lsu_done) m_lsu_busy = 0;
      m_gv = {gl, g1, g0};
      m_gi = '0;
      if (g0) m_gi[3:0]  = 4'(w0);
      if (g1) m_gi[7:4]  = 4'(w1);
      if (gl) m_gi[11:8] = 4'(wl);
      m_busy = {(m_lsu_busy | !fu_en[2]), !fu_en[1], !fu_en[0]};
    end
  endtask

  // One clock: advance model, clock DUT, compare just after the edge
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("grant_valid", 32'(grant_valid), 32'(m_gv));
    chk("grant_idx",   32'(grant_idx),   32'(m_gi));
    chk("fu_busy",     32'(fu_busy),     32'(m_busy));
  endtask

  initial begin
    m_gv = '0; m_gi = '0; m_busy = '0; m_lsu_busy = 0;
    rst = 1; flush = 0; lsu_done = 0;
    rs_ready = '1; rs_is_mem = '0; rs_rob_num = '0; rob_head = '0; fu_en = 3'b111;

    // Reset held two cycles with everything ready
    cyc();
    cyc();
    chk("rst_gv", 32'(grant_valid), 32'd0);
    chk("rst_busy", 32'(fu_busy), 32'd0);
    rst = 0; rs_ready = '0;
    cyc();
    chk("post_rst_gv", 32'(grant_valid), 32'd0);

    // Age order among ALU entries
    set_tag(3, 6'd7); set_tag(5, 6'd2); set_tag(9, 6'd4);
    rs_ready = 16'h0228;
    cyc();
    chk("age_gv", 32'(grant_valid), 32'b011);
    chk("age_alu0", 32'(grant_idx[3:0]), 32'd5);
    chk("age_alu1", 32'(grant_idx[7:4]), 32'd9);
    cyc();
    chk("age_next_gv", 32'(grant_valid), 32'b001);
    chk("age_next_alu0", 32'(grant_idx[3:0]), 32'd3);
    rs_ready = 16'h0008;
    cyc();
    rs_ready = '0;
    cyc();

    // In-flight mask: single grant over two ready cycles
    rs_ready = 16'h0004;
    cyc();
    chk("infl_first", 32'(grant_valid[0]), 32'd1);
    chk("infl_idx", 32'(grant_idx[3:0]), 32'd2);
    cyc();
    chk("infl_second", 32'(grant_valid[0]), 32'd0);
    rs_ready = '0;
    cyc();

    // LSU busy blocks the next mem op until lsu_done
    rs_is_mem = 16'h0012; set_tag(1, 6'd10); set_tag(4, 6'd11);
    rs_ready = 16'h0002;
    cyc();
    chk("lsu_grant", 32'(grant_idx[11:8]), 32'd1);
    chk("lsu_busy", 32'(fu_busy[2]), 32'd1);
    rs_ready = 16'h0012;
    cyc();
    rs_ready = 16'h0010;
    cyc();
    chk("lsu_blocked", 32'(grant_valid[2]), 32'd0);
    lsu_done = 1;
    cyc();
    chk("lsu_b2b_gv", 32'(grant_valid[2]), 32'd1);
    chk("lsu_b2b_idx", 32'(grant_idx[11:8]), 32'd4);
    chk("lsu_b2b_busy", 32'(fu_busy[2]), 32'd1);
    cyc();
    chk("lsu_done_idle", 32'(fu_busy[2]), 32'd0);
    lsu_done = 0; rs_ready = '0;
    cyc();

    // Wrap: head=62, tag 63 older than tag 1
    rob_head = 6'd62; rs_is_mem = 16'h00c0;
    set_tag(6, 6'd1); set_tag(7, 6'd63);
    rs_ready = 16'h00c0;
    cyc();
    chk("wrap_idx", 32'(grant_idx[11:8]), 32'd7);
    lsu_done = 1;
    cyc();
    chk("wrap_second", 32'(grant_idx[11:8]), 32'd6);
    rs_ready = '0;
    cyc();
    lsu_done = 0;
    cyc();

    // Flush mid-op with all FUs granted
    rob_head = '0; rs_is_mem = 16'h0004;
    set_tag(0, 6'd1); set_tag(1, 6'd2); set_tag(2, 6'd3);
    rs_ready = 16'h0007;
    cyc();
    chk("pre_flush_gv", 32'(grant_valid), 32'b111);
    flush = 1;
    cyc();
    chk("flush_gv", 32'(grant_valid), 32'd0);
    chk("flush_busy", 32'(fu_busy), 32'd0);
    flush = 0; rs_ready = '0; lsu_done = 1;
    cyc();
    chk("stale_done", 32'(fu_busy), 32'd0);
    lsu_done = 0;

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rs_ready   = 16'($urandom);
      rs_is_mem  = 16'($urandom);
      for (int i = 0; i < 16; i++) set_tag(i, 6'($urandom));
      rob_head   = 6'($urandom);
      fu_en      = {($urandom_range(3) != 0), ($urandom_range(3) != 0), ($urandom_range(3) != 0)};
      lsu_done   = ($urandom_range(3) == 0);
      flush      = ($urandom_range(19) == 0);
      rst        = ($urandom_range(49) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
